// File: rtl/lbm_field_streamer.sv
// lbm_field_streamer: captures per-cell LBM macroscopic fields into a FIFO and streams each cell as two beats
// Ports:
//   clk, rst (async active-low)      clock and reset
//   en, clear                        capture enable, synchronous flush
//   in_valid, rho/u_x/u_y/u_squared  per-cell sample from the solver
//   barrier                          sample is a barrier cell (velocities forced to zero)
//   m_data/m_valid/m_ready           output stream; m_user marks first beat of frame, m_last last beat
//   fifo_level, overflow             queued entries (excluding the holding register), sticky drop flag
//   frame_count                      number of completed frames of cell indices
module lbm_field_streamer #(
    parameter int DATA_WIDTH = 16,
    parameter int CELLS      = 2500,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          clear,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         rho,
    input  logic [DATA_WIDTH-1:0]         u_x,
    input  logic [DATA_WIDTH-1:0]         u_y,
    input  logic [DATA_WIDTH-1:0]         u_squared,
    input  logic                          barrier,
    output logic [2*DATA_WIDTH-1:0]       m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_last,
    output logic                          m_user,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [15:0]                   frame_count
);
    localparam int DW = DATA_WIDTH;
    localparam int IW = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = IW + 4 * DW;
    localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
    localparam logic [LW-1:0] DEPTH    = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

    // Entry layout {index, rho, u_squared, u_x, u_y}: the upper data half is beat 0, the lower half beat 1.
    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [15:0]     frame_q, frame_d;
    logic            ovf_q, ovf_d;
    logic            accept, full, empty, push, pop, wrap;
    logic [DW-1:0]   keep;
    logic [EW-1:0]   wr_entry, head, hold_q;
    state_t          state_q;
    logic [2*DW-1:0] data_q;
    logic            valid_q, last_q, user_q;

    assign accept   = en & in_valid & ~clear;
    assign full     = level_q == DEPTH;
    assign empty    = level_q == '0;
    // Fullness is judged on the pre-edge level, so a pop in the same cycle does not make room.
    assign push     = accept & ~full;
    assign pop      = ~clear & ~empty & (state_q == IDLE || (state_q == BEAT1 && m_ready));
    assign wrap     = idx_q == LAST_IDX;
    assign keep     = {DW{~barrier}};
    assign wr_entry = {idx_q, rho, u_squared & keep, u_x & keep, u_y & keep};
    assign head     = mem_q[rd_ptr_q];

    // Dropped samples still advance the index so the stream stays aligned to the lattice.
    always_comb begin
        idx_d    = clear ? '0 : accept ? (wrap ? '0 : idx_q + IW'(1)) : idx_q;
        frame_d  = clear ? '0 : (accept & wrap) ? frame_q + 16'd1 : frame_q;
        ovf_d    = ~clear & (ovf_q | (accept & full));
        wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(push);
        rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(pop);
        level_d  = clear ? '0 : level_q + LW'(push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_entry;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            idx_q    <= '0;
            frame_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            idx_q    <= idx_d;
            frame_q  <= frame_d;
            ovf_q    <= ovf_d;
        end
    end

    // Output FSM: one popped entry is held while its two beats are presented.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (clear) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            user_q  <= 1'b0;
            last_q  <= 1'b0;
        end else if (pop) begin
            state_q <= BEAT0;
            hold_q  <= head;
            valid_q <= 1'b1;
            data_q  <= head[4*DW-1 -: 2*DW];
            user_q  <= head[EW-1 -: IW] == '0;
            last_q  <= 1'b0;
        end else if (state_q == BEAT0 && m_ready) begin
            state_q <= BEAT1;
            data_q  <= hold_q[2*DW-1:0];
            user_q  <= 1'b0;
            last_q  <= hold_q[EW-1 -: IW] == LAST_IDX;
        end else if (state_q == BEAT1 && m_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end
    end

    assign m_data      = data_q;
    assign m_valid     = valid_q;
    assign m_user      = user_q;
    assign m_last      = last_q;
    assign fifo_level  = level_q;
    assign overflow    = ovf_q;
    assign frame_count = frame_q;
endmodule

// File: doc/lbm_field_streamer.md
LBM_FIELD_STREAMER -- requirements
Module: lbm_field_streamer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of each macroscopic field.
REQ-002 SHALL have parameter CELLS, default 2500, lattice cells per frame (50x50).
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, entries, power of two.
REQ-004 SHALL have port clk  in  1  single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  in  1  capture enable.
REQ-007 SHALL have port clear  in  1  synchronous flush of FIFO, counters and flags.
REQ-008 SHALL have port in_valid  in  1  one-cycle pulse per cell from the solver's collider_ready.
REQ-009 SHALL have ports rho, u_x, u_y, u_squared  in  DATA_WIDTH each  solver macroscopic outputs for the current cell.
REQ-010 SHALL have port barrier  in  1  current cell is a barrier.
REQ-011 SHALL have port m_data  out  2*DATA_WIDTH  stream beat.
REQ-012 SHALL have ports m_valid out 1, m_ready in 1, m_last out 1 (last beat of frame), m_user out 1 (first beat of frame).
REQ-013 SHALL have ports fifo_level  out  log2(FIFO_DEPTH)+1; overflow  out  1 sticky; frame_count  out  16.

Function
REQ-014 SHALL accept a sample on a rising edge with en=1, in_valid=1, clear=0.
REQ-015 Accepted sample SHALL carry cell index (0..CELLS-1); index increments per accepted sample and wraps CELLS-1 -> 0, incrementing frame_count (wraps 0xFFFF -> 0).
REQ-016 Barrier sample SHALL store rho unchanged and u_x=u_y=u_squared=0.
REQ-017 Accepted sample SHALL be pushed into the FIFO with its index unless FIFO is full.
REQ-018 Full is judged before a same-cycle pop: push while full SHALL be dropped even if a pop occurs that cycle.
REQ-019 A dropped sample SHALL set overflow and still advance cell index and frame_count (grid alignment kept).
REQ-020 Output FSM states SHALL be IDLE, BEAT0, BEAT1.
REQ-021 IDLE: FIFO non-empty -> pop into holding register, go BEAT0; else stay.
REQ-022 BEAT0: m_valid=1, m_data={rho,u_squared}, m_user=(index==0), m_last=0; m_ready=1 -> BEAT1.
REQ-023 BEAT1: m_valid=1, m_data={u_x,u_y}, m_user=0, m_last=(index==CELLS-1); m_ready=1 -> pop and BEAT0 if FIFO non-empty, else IDLE.
REQ-024 m_valid SHALL be 0 in IDLE; m_data/m_last/m_user SHALL hold stable while m_valid=1 and m_ready=0.
REQ-025 Latency: sample accepted at edge N into empty FIFO with FSM IDLE SHALL give m_valid=1 after edge N+1.
REQ-026 Back-to-back: sustained m_ready=1 SHALL give one beat per cycle with no bubble between cells.
REQ-027 fifo_level SHALL equal stored entries (excluding holding register), updated every edge, including simultaneous push+pop.
REQ-028 en=0 SHALL block capture only; output draining continues.
REQ-029 clear=1 SHALL empty FIFO, zero cell index, frame_count and overflow, force IDLE; it overrides a same-cycle push.

Reset
REQ-030 On rst=0 (async) SHALL drive m_valid=0, m_data=0, m_last=0, m_user=0, fifo_level=0, overflow=0, frame_count=0, cell index=0, state IDLE.
REQ-031 Reset asserted mid-beat SHALL drop the in-flight beat and all FIFO contents; release resumes from index 0.

Verification
REQ-032 Single sample rho=0x1000,u_x=0x0010,u_y=0xFFF0,u_squared=0x0002, m_ready=1 -> m_valid after edge N+1: beat {0x1000,0x0002} m_user=1, then {0x0010,0xFFF0}.
REQ-033 2500 samples, m_ready=1 -> 5000 beats, m_user only on beat 0, m_last only on beat 4999, frame_count=1.
REQ-034 m_ready=0, 17 samples, FIFO_DEPTH=16 -> fifo_level=16, one held, 17th... first beat held, overflow=0; 18th sample -> overflow=1, index=18.
REQ-035 barrier=1 with u_x=0x0123 -> beats {rho,0x0000},{0x0000,0x0000}.
REQ-036 m_ready toggling every cycle -> m_data stable across stalls, no lost or duplicated beats.
REQ-037 rst pulsed low while in BEAT1 with 5 entries queued -> m_valid=0 immediately, fifo_level=0, next sample streams with m_user=1.
